// File: rtl/store_split_sequencer.sv
//============================================================================
// Module   : store_split_sequencer
// Purpose  : Turns one byte-masked LSU store into one or two word-aligned
//            bus write beats. A store that straddles a word boundary is
//            split into two consecutive beats, lower word first.
// Ports    : clk, resetn (async, active low)
//            ReqValid/ReqReady/ReqSize/ReqAdr/ReqData  - store request
//            BusValid/BusReady/BusAdr/BusWData/BusByteMask - bus write beat
//            StoreDone  - pulse after the last beat of a store is accepted
//            StoreFault - pulse for a rejected crossing store
// Options  : STORE_MISALIGN_FAULT_EN - crossing stores are faulted instead
//            of split; without it StoreFault is tied to 0.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module store_split_sequencer #(
    parameter int WORDLEN = 64,
    parameter int ADRLEN  = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic [2:0]           ReqSize,
    input  logic [ADRLEN-1:0]    ReqAdr,
    input  logic [WORDLEN-1:0]   ReqData,
    output logic                 BusValid,
    input  logic                 BusReady,
    output logic [ADRLEN-1:0]    BusAdr,
    output logic [WORDLEN-1:0]   BusWData,
    output logic [WORDLEN/8-1:0] BusByteMask,
    output logic                 StoreDone,
    output logic                 StoreFault
);

    localparam int c_NB = WORDLEN / 8;
    localparam int c_OW = $clog2(c_NB);

    localparam logic [2:0]          c_MAXSZ  = 3'(c_OW);
    localparam logic [c_OW+1:0]     c_ONE_SZ = 1;
    localparam logic [2*c_NB-1:0]   c_ONE_M2 = 1;
    localparam logic [ADRLEN-1:0]   c_STEP   = ADRLEN'(c_NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Request decode
    logic [2:0]           w_esize;
    logic [c_OW+1:0]      w_nbytes;
    logic [2*c_NB-1:0]    w_lowm;
    logic [c_OW-1:0]      w_ofs;
    logic [2*c_NB-1:0]    w_mask2;
    logic [WORDLEN-1:0]   w_data_m;
    logic [2*WORDLEN-1:0] w_data2;
    logic [ADRLEN-1:0]    w_word_adr;
    logic                 w_cross;

    // Control strobes
    logic w_accept;
    logic w_load_hi;
    logic w_done;
    logic w_fault_now;

    // Registered state
    logic                 r_bus_valid;
    logic [ADRLEN-1:0]    r_bus_adr;
    logic [WORDLEN-1:0]   r_bus_wdata;
    logic [c_NB-1:0]      r_bus_mask;
    logic [WORDLEN-1:0]   r_hi_data;
    logic [c_NB-1:0]      r_hi_mask;
    logic                 r_cross;
    logic                 r_done;

    // Sizes above one word saturate to a full word
    assign w_esize    = (ReqSize > c_MAXSZ) ? c_MAXSZ : ReqSize;
    assign w_nbytes   = c_ONE_SZ << w_esize;
    assign w_lowm     = (c_ONE_M2 << w_nbytes) - c_ONE_M2;
    assign w_ofs      = ReqAdr[c_OW-1:0];
    assign w_mask2    = w_lowm << w_ofs;
    assign w_word_adr = {ReqAdr[ADRLEN-1:c_OW], {c_OW{1'b0}}};
    assign w_cross    = |w_mask2[2*c_NB-1:c_NB];

    // Zero the bytes above the access size before shifting so that
    // disabled lanes always carry zero data.
    for (genvar i = 0; i < c_NB; i++) begin : g_lane
        assign w_data_m[8*i +: 8] = w_lowm[i] ? ReqData[8*i +: 8] : 8'h00;
    end

    assign w_data2  = {{WORDLEN{1'b0}}, w_data_m} << {w_ofs, 3'b000};
    assign w_accept = ReqValid && (r_state == IDLE);

`ifdef STORE_MISALIGN_FAULT_EN
    assign w_fault_now = w_accept && w_cross;
`else
    assign w_fault_now = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load_hi   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (ReqValid) begin
                    w_state_nxt = BEAT0;
                end
            end
            BEAT0: begin
`ifdef STORE_MISALIGN_FAULT_EN
                // Faulted store: no beat was presented, done/fault were
                // already registered at accept, just return to IDLE.
                if (r_cross) begin
                    w_state_nxt = IDLE;
                end else
`endif
                if (BusReady) begin
                    if (r_cross) begin
                        w_state_nxt = BEAT1;
                        w_load_hi   = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (BusReady) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus beat registers; the upper half is parked until beat 1 starts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus_valid <= 1'b0;
            r_bus_adr   <= '0;
            r_bus_wdata <= '0;
            r_bus_mask  <= '0;
            r_hi_data   <= '0;
            r_hi_mask   <= '0;
            r_cross     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done || w_fault_now;
            if (w_accept) begin
                r_bus_valid <= !w_fault_now;
                r_bus_adr   <= w_word_adr;
                r_bus_mask  <= w_mask2[c_NB-1:0];
                r_bus_wdata <= w_data2[WORDLEN-1:0];
                r_hi_mask   <= w_mask2[2*c_NB-1:c_NB];
                r_hi_data   <= w_data2[2*WORDLEN-1:WORDLEN];
                r_cross     <= w_cross;
            end else if (w_load_hi) begin
                r_bus_adr   <= r_bus_adr + c_STEP;
                r_bus_mask  <= r_hi_mask;
                r_bus_wdata <= r_hi_data;
            end else if (w_done) begin
                r_bus_valid <= 1'b0;
            end
        end
    end

`ifdef STORE_MISALIGN_FAULT_EN
    logic r_fault;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_now;
        end
    end

    assign StoreFault = r_fault;
`else
    assign StoreFault = 1'b0;
`endif

    assign ReqReady    = (r_state == IDLE);
    assign BusValid    = r_bus_valid;
    assign BusAdr      = r_bus_adr;
    assign BusWData    = r_bus_wdata;
    assign BusByteMask = r_bus_mask;
    assign StoreDone   = r_done;

endmodule

`default_nettype wire
